rr_arbiter_disp: RTL and testbench

- 8-requester round-robin arbiter that shares one display/resource slot between requesters.
- Grants one requester at a time and holds the grant until release or timeout.
- Reports the winner as one-hot, as a 3-bit index and as a seven-segment pattern, using the same digit encoding as the team's priority-encoder display block.
- Sits between board switches/requesting logic and the shared resource plus display.

---
 rtl/rr_arbiter_disp_pkg.sv | 38 +++
 rtl/rr_arbiter_disp_if.sv | 22 ++
 rtl/rr_arbiter_disp_pick.sv | 27 ++
 rtl/rr_arbiter_disp.sv | 99 +++++++++
 tb/tb_rr_arbiter_disp.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_disp_pkg.sv
// Shared types and constants for the round-robin arbiter with digit display.
package rr_arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

  // Active-low seven-segment patterns, bits[7:1]=a..g, bit0=dp.
  localparam logic [7:0] SEG_DASH = 8'b1111_1100;

  localparam logic [7:0] SEG_DIGIT [0:N-1] = '{
    8'b0000_0010,
    8'b1001_1110,
    8'b0010_0100,
    8'b0000_1100,
    8'b1001_1000,
    8'b0100_1000,
    8'b0100_0000,
    8'b0001_1110
  };

  function automatic logic [7:0] seg_of(input logic [IDX_W-1:0] idx);
    return SEG_DIGIT[idx];
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_disp_if.sv
// Request/grant/display bundle between requesters and the arbiter.
interface rr_arbiter_disp_if;

  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic [7:0] seg;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_vld, seg
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_vld, seg
  );

endinterface

// File: rtl/rr_arbiter_disp_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [2*N-2:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate so ptr lands at bit 0, take lowest set bit, rotate the index back.
  always_comb begin
    dbl = {req[N-2:0], req};
    rot = dbl[ptr +: N];
    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
    win_idx = ptr + off;
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter_disp.sv
// 8-way round-robin arbiter with bounded hold time and seven-segment winner display.
module rr_arbiter_disp
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst_n,
  rr_arbiter_disp_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q,   state_d;
  logic [N-1:0]     gnt_q,     gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [7:0]       seg_q,     seg_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic [7:0]       cnt_q,     cnt_d;

  logic [IDX_W-1:0] win_idx;
  logic             any;
  logic             rel;

  rr_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any     (any)
  );

  // Next-state and next-output logic for the grant FSM.
  // The pointer advances on the edge that leaves GRANT, so the RELEASE cycle
  // can already arbitrate with it; this keeps the gap between owners at one cycle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    seg_d     = seg_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rel       = bus.done | ~bus.req[gnt_idx_q] | ~bus.en | (cnt_q == CNT_LAST);

    case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (bus.en && any) begin
          state_d   = GRANT;
          gnt_d     = onehot(win_idx);
          gnt_idx_d = win_idx;
          gnt_vld_d = 1'b1;
          seg_d     = seg_of(win_idx);
          cnt_d     = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          seg_d     = SEG_DASH;
          ptr_d     = gnt_idx_q + 3'd1;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      seg_q     <= SEG_DASH;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      seg_q     <= seg_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_rr_arbiter_disp.sv
// Self-checking bench for rr_arbiter_disp against a behavioural ownership model.
module tb_rr_arbiter_disp;

  localparam int MAXH = 16;
  localparam logic [7:0] TB_DASH = 8'b1111_1100;
  localparam logic [7:0] TB_SEG [0:7] = '{
    8'b0000_0010, 8'b1001_1110, 8'b0010_0100, 8'b0000_1100,
    8'b1001_1000, 8'b0100_1000, 8'b0100_0000, 8'b0001_1110
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_arbiter_disp_if bus ();

  rr_arbiter_disp #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the slot, for how many cycles, where the search starts.
  int m_owner;
  int m_last;
  int m_held;
  int m_ptr;

  task automatic m_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_ptr   = 0;
  endtask

  task automatic m_step(input bit en, input logic [7:0] req, input bit done);
    int w;
    if (m_owner >= 0) begin
      if (done || !req[m_owner] || !en || m_held == MAXH) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (en && req != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        w = (m_ptr + k) % 8;
        if (req[w]) begin
          m_owner = w;
          m_last  = w;
          m_held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_outs();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    chk("gnt",     32'(bus.gnt),     32'(eg));
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_last));
    chk("gnt_vld", 32'(bus.gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("seg",     32'(bus.seg),     32'((m_owner >= 0) ? TB_SEG[m_last] : TB_DASH));
  endtask

  // Observed-behaviour trackers for order, gap and hold-length checks.
  int  grants[$];
  int  gaps[$];
  int  holds[$];
  bit  prev_vld;
  bit  seen_grant;
  int  gap_len;
  int  hold_len;

  task automatic clear_track();
    grants.delete();
    gaps.delete();
    holds.delete();
    prev_vld   = 1'b0;
    seen_grant = 1'b0;
    gap_len    = 0;
    hold_len   = 0;
  endtask

  task automatic cycle(input bit en, input logic [7:0] req, input bit done);
    bus.en   = en;
    bus.req  = req;
    bus.done = done;
    @(posedge clk);
    m_step(en, req, done);
    @(negedge clk);
    check_outs();
    if (bus.gnt_vld && !prev_vld) begin
      grants.push_back(int'(bus.gnt_idx));
      if (seen_grant) gaps.push_back(gap_len);
      seen_grant = 1'b1;
      hold_len   = 0;
    end
    if (!bus.gnt_vld && prev_vld) holds.push_back(hold_len);
    if (bus.gnt_vld) begin
      hold_len++;
      gap_len = 0;
    end else begin
      gap_len++;
    end
    prev_vld = bus.gnt_vld;
  endtask

  task automatic do_reset(input bit en, input logic [7:0] req);
    @(negedge clk);
    bus.en   = en;
    bus.req  = req;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    #1;
    m_reset();
    check_outs();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
    clear_track();
  endtask

  logic [7:0] cur_req;

  initial begin
    bus.en   = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    m_reset();
    clear_track();

    // Reset with everyone requesting, then full rotation with done two cycles into each grant.
    do_reset(1'b1, 8'hFF);
    chk("rst_seg_dash", 32'(bus.seg), 32'(TB_DASH));
    cycle(1'b1, 8'hFF, 1'b0);
    chk("first_gnt", 32'(bus.gnt), 32'h01);
    for (int c = 0; c < 40; c++)
      cycle(1'b1, 8'hFF, (m_owner >= 0 && m_held == 2));
    for (int k = 0; k < 9; k++) begin
      if (k < grants.size()) chk("rotate_order", 32'(grants[k]), 32'(k % 8));
      else chk("rotate_count", 32'(grants.size()), 32'(k + 1));
    end
    foreach (gaps[g]) chk("rotate_gap", 32'(gaps[g]), 32'd1);

    // Single requester 5 with no done: timeout after MAXH cycles, one-cycle gap, wins again.
    do_reset(1'b1, 8'h20);
    for (int c = 0; c < 40; c++) cycle(1'b1, 8'h20, 1'b0);
    chk("hold_count", 32'(holds.size() >= 2), 32'd1);
    if (holds.size() >= 2) begin
      chk("hold_len0", 32'(holds[0]), 32'(MAXH));
      chk("hold_len1", 32'(holds[1]), 32'(MAXH));
    end
    if (gaps.size() >= 1) chk("hold_gap", 32'(gaps[0]), 32'd1);
    else chk("hold_gap_seen", 32'(gaps.size()), 32'd1);
    if (grants.size() >= 2) chk("hold_regrant", 32'(grants[1]), 32'd5);

    // Owner 3 drops its request; next search starts at 4 so 7 beats 0.
    do_reset(1'b1, 8'h08);
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'h08, 1'b0);
    chk("own3", 32'(bus.gnt), 32'h08);
    cycle(1'b1, 8'h81, 1'b0);
    chk("drop_rel", 32'(bus.gnt), 32'h00);
    cycle(1'b1, 8'h81, 1'b0);
    chk("next_is_7", 32'(bus.gnt_idx), 32'd7);

    // Enable dropped mid-grant, then held low with everyone requesting.
    do_reset(1'b1, 8'hFF);
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0);
    chk("en_drop_rel", 32'(bus.gnt_vld), 32'd0);
    for (int c = 0; c < 5; c++) cycle(1'b0, 8'hFF, 1'b0);
    chk("en_low_gnt", 32'(bus.gnt), 32'h00);
    chk("en_low_seg", 32'(bus.seg), 32'(TB_DASH));

    // Asynchronous reset in the middle of a grant to requester 5.
    do_reset(1'b1, 8'h20);
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'h20, 1'b0);
    chk("own5", 32'(bus.gnt_idx), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_gnt", 32'(bus.gnt), 32'h00);
    chk("async_idx", 32'(bus.gnt_idx), 32'd0);
    check_outs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_track();
    cycle(1'b1, 8'hFF, 1'b0);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h01);

    // Randomised traffic: slowly changing requests, occasional enable drops and stray done pulses.
    do_reset(1'b1, 8'h00);
    cur_req = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) cur_req = 8'($urandom) & 8'($urandom);
      cycle($urandom_range(0, 9) != 0, cur_req, $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
